// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter for the ALU and load/store result streams
module wb_arbiter_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

module wb_arbiter #(
    parameter int VLEN    = 128,
    parameter int XLEN    = 32,
    parameter int POS_WID = 3,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [5:0]         alu_rd,
    input  logic [VLEN-1:0]    alu_value,
    input  logic [POS_WID-1:0] alu_pos,
    input  logic               ls_valid,
    output logic               ls_ready,
    input  logic [5:0]         ls_rd,
    input  logic [VLEN-1:0]    ls_value,
    input  logic [POS_WID-1:0] ls_pos,
    output logic               wb_valid,
    output logic [5:0]         wb_rd,
    output logic [VLEN-1:0]    wb_value,
    output logic [POS_WID-1:0] wb_pos,
    output logic               wb_src
);
    localparam int EW = 6 + VLEN + POS_WID;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]      alu_count, ls_count;
    logic [EW-1:0]      alu_head, ls_head, head;
    logic               alu_push, ls_push, alu_pop, ls_pop;
    logic               ne_a, ne_l, grant, grant_ls;
    logic [5:0]         head_rd;
    logic [VLEN-1:0]    head_value;
    logic [POS_WID-1:0] head_pos;

    logic               last_grant_q, last_grant_d;
    logic               wb_valid_q, wb_valid_d;
    logic [5:0]         wb_rd_q, wb_rd_d;
    logic [VLEN-1:0]    wb_value_q, wb_value_d;
    logic [POS_WID-1:0] wb_pos_q, wb_pos_d;
    logic               wb_src_q, wb_src_d;

    // Ready looks only at the count at the start of the cycle: a full FIFO never accepts.
    assign alu_ready = !rst && (alu_count != CW'(DEPTH));
    assign ls_ready  = !rst && (ls_count != CW'(DEPTH));
    assign alu_push  = alu_valid && alu_ready;
    assign ls_push   = ls_valid && ls_ready;

    assign ne_a     = alu_count != '0;
    assign ne_l     = ls_count != '0;
    assign grant    = !rst && (ne_a || ne_l);
    assign grant_ls = ne_l && (!ne_a || !last_grant_q);
    assign alu_pop  = grant && !grant_ls;
    assign ls_pop   = grant && grant_ls;

    wb_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .wdata ({alu_rd, alu_value, alu_pos}),
        .pop   (alu_pop),
        .head  (alu_head),
        .count (alu_count)
    );

    wb_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_ls_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ls_push),
        .wdata ({ls_rd, ls_value, ls_pos}),
        .pop   (ls_pop),
        .head  (ls_head),
        .count (ls_count)
    );

    assign head       = grant_ls ? ls_head : alu_head;
    assign head_rd    = head[EW-1 -: 6];
    assign head_value = head[POS_WID +: VLEN];
    assign head_pos   = head[POS_WID-1:0];

    always_comb begin
        last_grant_d = last_grant_q;
        wb_valid_d   = grant;
        wb_rd_d      = wb_rd_q;
        wb_value_d   = wb_value_q;
        wb_pos_d     = wb_pos_q;
        wb_src_d     = wb_src_q;
        if (grant) begin
            last_grant_d = grant_ls;
            wb_rd_d      = head_rd;
            wb_pos_d     = head_pos;
            wb_src_d     = grant_ls;
            // Scalar destinations only carry XLEN bits; the upper lanes are written as zero.
            wb_value_d   = head_rd[5] ? head_value
                                      : {{(VLEN-XLEN){1'b0}}, head_value[XLEN-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_value_q   <= '0;
            wb_pos_q     <= '0;
            wb_src_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_value_q   <= wb_value_d;
            wb_pos_q     <= wb_pos_d;
            wb_src_q     <= wb_src_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_value = wb_value_q;
    assign wb_pos   = wb_pos_q;
    assign wb_src   = wb_src_q;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that shares the register file's single write port between the ALU and load/store result streams. Each source pushes completed results into its own small FIFO through a valid/ready handshake. The arbiter drains at most one entry per cycle, using round-robin priority when both FIFOs hold data, and drives the registered write-back bus. That bus feeds both the register file and the scoreboard's completion logic.

## Interface
- VLEN, 128, vector register / write-back data width
- XLEN, 32, scalar register width (XLEN < VLEN)
- POS_WID, 3, scoreboard entry index width
- DEPTH, 2, entries per source FIFO (power of two, >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU FIFO can accept
- alu_rd  in  6  destination (bit 5: 0 scalar, 1 vector; bits 4:0 index)
- alu_value  in  VLEN  result data
- alu_pos  in  POS_WID  scoreboard entry of the instruction
- ls_valid / ls_ready / ls_rd / ls_value / ls_pos  same as the ALU set, for load/store results
- wb_valid  out  1  write-back strobe (one cycle per result)
- wb_rd  out  6  destination register
- wb_value  out  VLEN  write data
- wb_pos  out  POS_WID  scoreboard entry being completed
- wb_src  out  1  0 = ALU, 1 = LS

## Operation
- **Per-source FIFO.** Each source has a FIFO of DEPTH entries of {rd, value, pos}, with read/write pointers and a count of width log2(DEPTH)+1.
- **Push.** A push happens when x_valid && x_ready.
- **Ready.** x_ready = !rst && (count_x != DEPTH).
  - Ready is computed from the count at the start of the cycle.
  - A full FIFO that pops this cycle still shows ready = 0. There is no push-on-pop-when-full.
- **Grant.** Each cycle, with ne_a = count_alu != 0 and ne_l = count_ls != 0:
  - neither non-empty: no grant.
  - only one non-empty: that source is granted.
  - both non-empty: the source that is not last_grant is granted.
- **Pop.** The granted FIFO pops its head. last_grant is updated to the granted source.
- **Output register.** The popped head is loaded into the output register at the same edge: wb_valid <= 1, wb_rd, wb_pos, wb_src.
- **No grant.** wb_valid <= 0. wb_rd, wb_value, wb_pos and wb_src hold their previous values.
- **Scalar write data.** When the popped rd[5] == 0:
  - wb_value[XLEN-1:0] = value[XLEN-1:0];
  - wb_value[VLEN-1:XLEN] = 0.
- **Vector write data.** When rd[5] == 1, wb_value = value, unmodified.
- **No bypass.** A result is never written back in the cycle it is pushed.
- **Simultaneous push and pop.** A push and a pop on the same FIFO in the same cycle is legal when count is between 1 and DEPTH-1. The count is unchanged and both pointers advance.
- **Pointer wrap.** Pointers wrap modulo DEPTH.
- **Ordering.** Within one source, results are written back in push order. No ordering is enforced across sources.
- **rst = 1, mid-operation included.** All FIFO contents are discarded: counts = 0, pointers = 0. Inputs are ignored in the reset cycle.

## Timing
- **Reset values:**
  - wb_valid = 0, wb_rd = 0, wb_value = 0, wb_pos = 0, wb_src = 0.
  - last_grant = 1 (LS), so the ALU wins the first tie.
  - alu_ready and ls_ready = 0 while rst = 1, and 1 in the first cycle after reset.
- **Latency.** A result pushed at edge t appears as wb_valid = 1 after edge t+1 at the earliest. That is 1 cycle from accept to write-back strobe.
- **Throughput.** One write-back per cycle. Under sustained contention from both sources the grants alternate ALU, LS, ALU, ...
- **Worst-case wait.** With both sources busy, an entry waits at most 2*DEPTH-1 cycles after becoming head-eligible.
- **No back-pressure.** There is no back-pressure on the wb bus; the register file accepts every strobe.

## Test plan
- **Single ALU result.** Push alu {rd=6'h21, value=128'hA5.., pos=3} at cycle 0.
  - Cycle 1: wb_valid = 1, wb_rd = 6'h21, wb_value = 128'hA5.., wb_pos = 3, wb_src = 0.
  - Cycle 2: wb_valid = 0.
- **Scalar zero-extension.** Push ls {rd=6'h05, value=all-ones}.
  - Required: wb_value = 128'h0000..00FFFFFFFF and wb_src = 1.
- **Contention.** Both sources push every cycle for 6 cycles.
  - Required wb_src sequence: 0,1,0,1,0,1.
  - Each source's ready drops to 0 once its FIFO is full.
  - Every pushed pos appears exactly once, in per-source order.
- **Full FIFO.** Hold ls_valid = 1 with no ALU traffic. The FIFO never fills because it drains 1 per cycle.
  - Then stall the drain by keeping the ALU FIFO busy: preload ALU with 2 entries plus continuous pushes.
  - Required: ls_ready = 0 exactly when count_ls == 2, and no entry is lost or duplicated.
- **Wrap-around.** Push 5 ALU entries with pos = 0..4 at a spacing that keeps count ≤ 2.
  - Required: wb_pos = 0,1,2,3,4 in order across the pointer wrap.
- **Reset mid-operation.** Fill both FIFOs, then assert rst for 1 cycle.
  - During reset: wb_valid = 0 and both ready = 0.
  - After reset: ready = 1 and no stale entries are ever written back.
  - Next tie is granted to the ALU.
